basic_func_node: RTL and testbench

Parametrised leaf node for the Maltsev computation-tree datapath. It evaluates one basic function over an N-argument vector of W-bit words: zero, successor, or projection. It uses the tree's start/ready handshake, with a configurable latency so sibling leaves can be balanced. It generalises the fixed 16-bit, 3-input projection leaf, and parent composition and recursion nodes instantiate it directly.

---
 rtl/maltsev_node_pkg.sv | 18 +
 rtl/start_edge_det.sv | 27 ++
 rtl/basic_func_node.sv | 118 +++++++++++
 tb/tb_basic_func_node.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maltsev_node_pkg.sv
// Shared constants for the Maltsev computation-tree nodes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the basic-function mode codes and the start/ready handshake state
// encoding used by the leaf, composition and recursion nodes.
package maltsev_node_pkg;

    localparam int MODE_ZERO = 0;
    localparam int MODE_SUCC = 1;
    localparam int MODE_PROJ = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } node_state_t;

endpackage

// File: rtl/start_edge_det.sv
// Start-edge detector: turns a level start request into a one-cycle pulse.
// Latency: START is combinational from ST against the registered previous ST.
// Backpressure: none; a held ST yields one pulse, ST must drop for a sampled cycle to re-arm.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset; masks START but does not stop st_q sampling
//   ST    level start request
//   START one-cycle pulse on an accepted rising edge of ST
module start_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic ST,
    output logic START
);

    logic st_q;

    // st_q keeps sampling through reset so an edge seen during RST is
    // consumed and cannot fire on the first cycle after reset releases.
    always_ff @(posedge CLK) begin
        st_q <= ST;
    end

    assign START = ST & ~st_q & ~RST;

endmodule

// File: rtl/basic_func_node.sv
// Maltsev tree leaf: evaluates ZERO, SUCC or PROJ over a captured N-word argument vector.
// Latency: RES/RD update LATENCY edges after the accepted start edge.
// Backpressure: RD low while busy; a new start while busy restarts and discards the old evaluation.
//
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   ST        start level; each rising edge requests one evaluation
//   IN        NARGS words of WIDTH bits, word i at IN[i*WIDTH +: WIDTH]
//   RD        ready: RES valid and node idle
//   RES       result, held until the next completion
//   OVF       SUCC wrap flag, only present when NODE_OVF_EN is defined
module basic_func_node
    import maltsev_node_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NARGS    = 3,
    parameter int MODE     = 2,
    parameter int PROJ_IDX = 2,
    parameter int LATENCY  = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ST,
    input  logic [NARGS*WIDTH-1:0] IN,
    output logic                   RD,
    output logic [WIDTH-1:0]       RES
`ifdef NODE_OVF_EN
    ,
    output logic                   OVF
`endif
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (NARGS < 1) begin : g_chk_nargs
        $fatal(1, "basic_func_node: NARGS must be >= 1");
    end
    if (PROJ_IDX < 0 || PROJ_IDX >= NARGS) begin : g_chk_idx
        $fatal(1, "basic_func_node: PROJ_IDX must be in 0..NARGS-1");
    end
    if (LATENCY < 1) begin : g_chk_lat
        $fatal(1, "basic_func_node: LATENCY must be >= 1");
    end
    if (MODE < 0 || MODE > 2) begin : g_chk_mode
        $fatal(1, "basic_func_node: MODE must be 0, 1 or 2");
    end

    node_state_t      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] args_q [NARGS];
    logic             start;
    logic [WIDTH-1:0] sel_w;
    logic [WIDTH-1:0] res_nxt;

    start_edge_det u_start_edge_det (
        .CLK   (CLK),
        .RST   (RST),
        .ST    (ST),
        .START (start)
    );

    // Functions see only the captured arguments, never live IN.
    assign sel_w = args_q[PROJ_IDX];

    always_comb begin
        res_nxt = '0;
        case (MODE)
            MODE_SUCC: res_nxt = sel_w + WIDTH'(1);
            MODE_PROJ: res_nxt = sel_w;
            default:   res_nxt = '0;
        endcase
    end

`ifdef NODE_OVF_EN
    logic ovf_nxt;
    assign ovf_nxt = (MODE == MODE_SUCC) && (&sel_w);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            RD    <= 1'b1;
            RES   <= '0;
`ifdef NODE_OVF_EN
            OVF   <= 1'b0;
`endif
            for (int i = 0; i < NARGS; i++) begin
                args_q[i] <= '0;
            end
        end else begin
            // A finishing evaluation still retires on its completion edge;
            // a start on that same edge then begins as if from IDLE, so RD
            // stays low with no gap.
            if (state == BUSY && cnt == '0) begin
                RES   <= res_nxt;
`ifdef NODE_OVF_EN
                OVF   <= ovf_nxt;
`endif
                RD    <= 1'b1;
                state <= IDLE;
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
            end

            // Start in IDLE, or restart in BUSY: recapture and reload.
            if (start) begin
                for (int i = 0; i < NARGS; i++) begin
                    args_q[i] <= IN[i*WIDTH +: WIDTH];
                end
                cnt   <= CW'(LATENCY - 1);
                RD    <= 1'b0;
                state <= BUSY;
            end
        end
    end

endmodule

// File: tb/tb_basic_func_node.sv
// Bench for basic_func_node: four leaves (PROJ lat1, SUCC lat1, ZERO lat4, PROJ lat3)
// driven by directed steps and random operations, checked against a transaction-level
// model that computes each result arithmetically from the argument words.
module tb_basic_func_node;

    logic        clk;
    logic        rst;
    logic        st   [4];
    logic [47:0] din  [4];
    logic        rd   [4];
    logic [15:0] res  [4];
`ifdef NODE_OVF_EN
    logic        ovf  [4];
`endif

    logic [15:0] m_res [4];
    int vectors;
    int miscompares;

    basic_func_node #(.WIDTH(16), .NARGS(3), .MODE(2), .PROJ_IDX(2), .LATENCY(1)) u_proj (
        .CLK(clk), .RST(rst), .ST(st[0]), .IN(din[0]), .RD(rd[0]), .RES(res[0])
`ifdef NODE_OVF_EN
        , .OVF(ovf[0])
`endif
    );

    basic_func_node #(.WIDTH(16), .NARGS(3), .MODE(1), .PROJ_IDX(0), .LATENCY(1)) u_succ (
        .CLK(clk), .RST(rst), .ST(st[1]), .IN(din[1]), .RD(rd[1]), .RES(res[1])
`ifdef NODE_OVF_EN
        , .OVF(ovf[1])
`endif
    );

    basic_func_node #(.WIDTH(16), .NARGS(3), .MODE(0), .PROJ_IDX(1), .LATENCY(4)) u_zero (
        .CLK(clk), .RST(rst), .ST(st[2]), .IN(din[2]), .RD(rd[2]), .RES(res[2])
`ifdef NODE_OVF_EN
        , .OVF(ovf[2])
`endif
    );

    basic_func_node #(.WIDTH(16), .NARGS(3), .MODE(2), .PROJ_IDX(1), .LATENCY(3)) u_lat3 (
        .CLK(clk), .RST(rst), .ST(st[3]), .IN(din[3]), .RD(rd[3]), .RES(res[3])
`ifdef NODE_OVF_EN
        , .OVF(ovf[3])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mode_of(input int d);
        case (d)
            0: return 2;
            1: return 1;
            2: return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int idx_of(input int d);
        case (d)
            0: return 2;
            1: return 0;
            2: return 1;
            default: return 1;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            0: return 1;
            1: return 1;
            2: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int word_of(input logic [47:0] a, input int idx);
        return int'((a >> (idx * 16)) & 48'hFFFF);
    endfunction

    // Reference: ZERO -> 0, SUCC -> (a+1) mod 2^16, PROJ -> a.
    function automatic logic [15:0] ref_eval(input int mode, input logic [47:0] a, input int idx);
        int w;
        w = word_of(a, idx);
        case (mode)
            0: return 16'h0000;
            1: return 16'((w + 1) % 65536);
            default: return 16'(w);
        endcase
    endfunction

    function automatic logic ref_ovf(input int mode, input logic [47:0] a, input int idx);
        return (mode == 1) && (word_of(a, idx) == 65535);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One complete operation on leaf d; assumes ST was low at the previous edge.
    task automatic do_op(input int d, input logic [47:0] args, input string tag);
        int lat;
        logic [15:0] exp_res;
        lat     = lat_of(d);
        exp_res = ref_eval(mode_of(d), args, idx_of(d));
        din[d] = args;
        st[d]  = 1'b1;
        tick();
        chk($sformatf("%s_rd_after_start", tag), 32'(rd[d]), 32'd0);
        din[d] = ~args;
        st[d]  = 1'b0;
        for (int i = 1; i < lat; i++) begin
            tick();
            chk($sformatf("%s_rd_busy%0d", tag, i), 32'(rd[d]), 32'd0);
            chk($sformatf("%s_res_hold%0d", tag, i), 32'(res[d]), 32'(m_res[d]));
        end
        tick();
        chk($sformatf("%s_rd_done", tag), 32'(rd[d]), 32'd1);
        chk($sformatf("%s_res", tag), 32'(res[d]), 32'(exp_res));
`ifdef NODE_OVF_EN
        chk($sformatf("%s_ovf", tag), 32'(ovf[d]), 32'(ref_ovf(mode_of(d), args, idx_of(d))));
`endif
        m_res[d] = exp_res;
    endtask

    initial begin
        logic [47:0] a1;
        logic [47:0] a2;
        logic [47:0] b;
        int comps;
        int lows;
        logic prev_rd;
        int d;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st[i]    = 1'b0;
            din[i]   = '0;
            m_res[i] = '0;
        end

        // Reset with ST toggling; the final reset edge carries a rising ST.
        tick();
        for (int i = 0; i < 4; i++) st[i] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) st[i] = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) st[i] = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_rd%0d", i), 32'(rd[i]), 32'd1);
            chk($sformatf("reset_res%0d", i), 32'(res[i]), 32'd0);
`ifdef NODE_OVF_EN
            chk($sformatf("reset_ovf%0d", i), 32'(ovf[i]), 32'd0);
`endif
        end
        // ST still high after reset: the consumed edge must not start anything.
        tick();
        chk("reset_edge_no_start_a", 32'(rd[0]), 32'd1);
        chk("reset_edge_no_start_b", 32'(rd[3]), 32'd1);
        tick();
        chk("reset_edge_no_start_c", 32'(rd[2]), 32'd1);
        for (int i = 0; i < 4; i++) st[i] = 1'b0;
        tick();

        // Directed PROJ, word 2 selected.
        do_op(0, {16'hBEEF, 16'h2222, 16'h1111}, "proj_beef");
        chk("proj_beef_literal", 32'(res[0]), 32'h0000BEEF);

        // SUCC wrap then a plain increment.
        do_op(1, {16'h1234, 16'h5678, 16'hFFFF}, "succ_wrap");
        chk("succ_wrap_literal", 32'(res[1]), 32'h00000000);
        do_op(1, {16'hFFFF, 16'hFFFF, 16'h0007}, "succ_seven");
        chk("succ_seven_literal", 32'(res[1]), 32'h00000008);

        // ZERO with LATENCY=4.
        do_op(2, {16'hAAAA, 16'h5555, 16'h1234}, "zero_lat4");

        // Prime the LATENCY=3 PROJ leaf with a known result.
        do_op(3, {16'h0101, 16'h4321, 16'h0202}, "lat3_prime");

        // Restart: second start two edges after the first, with new arg 0x00AA.
        a1 = {16'($urandom), 16'h7E57, 16'($urandom)};
        a2 = {16'($urandom), 16'h00AA, 16'($urandom)};
        din[3] = a1;
        st[3]  = 1'b1;
        tick();
        chk("restart_rd_k", 32'(rd[3]), 32'd0);
        st[3]  = 1'b0;
        din[3] = 48'h0;
        tick();
        chk("restart_rd_k1", 32'(rd[3]), 32'd0);
        din[3] = a2;
        st[3]  = 1'b1;
        tick();
        chk("restart_rd_j", 32'(rd[3]), 32'd0);
        chk("restart_res_j", 32'(res[3]), 32'(m_res[3]));
        st[3]  = 1'b0;
        din[3] = 48'h0;
        tick();
        chk("restart_rd_j1", 32'(rd[3]), 32'd0);
        chk("restart_no_first_arg", 32'(res[3]), 32'(m_res[3]));
        tick();
        chk("restart_rd_j2", 32'(rd[3]), 32'd0);
        tick();
        chk("restart_rd_j3", 32'(rd[3]), 32'd1);
        chk("restart_res_j3", 32'(res[3]), 32'h000000AA);
        m_res[3] = 16'h00AA;

        // ST held high for 10 edges: exactly one completion, RD low 3 cycles.
        b = {16'($urandom), 16'($urandom), 16'($urandom)};
        din[3]  = b;
        st[3]   = 1'b1;
        comps   = 0;
        lows    = 0;
        prev_rd = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 9) st[3] = 1'b0;
            if (rd[3] == 1'b0) lows++;
            if (prev_rd == 1'b0 && rd[3] == 1'b1) comps++;
            prev_rd = rd[3];
        end
        chk("hold_completions", 32'(comps), 32'd1);
        chk("hold_busy_cycles", 32'(lows), 32'd3);
        chk("hold_res", 32'(res[3]), 32'(ref_eval(2, b, 1)));
        m_res[3] = ref_eval(2, b, 1);

        // Random operations on randomly chosen leaves with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 3));
            b = {16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 3) == 0) begin
                b[idx_of(d)*16 +: 16] = 16'hFFFF;
            end
            do_op(d, b, $sformatf("rnd%0d_d%0d", n, d));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                chk($sformatf("rnd%0d_idle_rd", n), 32'(rd[d]), 32'd1);
            end
        end

        // Reset one edge into a LATENCY=3 evaluation.
        din[3] = {16'h1111, 16'h2222, 16'h3333};
        st[3]  = 1'b1;
        tick();
        chk("rstbusy_rd_k", 32'(rd[3]), 32'd0);
        st[3] = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_res[i] = '0;
        chk("rstbusy_rd", 32'(rd[3]), 32'd1);
        chk("rstbusy_res", 32'(res[3]), 32'd0);
        chk("rstbusy_res_other", 32'(res[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rstbusy_idle_rd%0d", i), 32'(rd[3]), 32'd1);
            chk($sformatf("rstbusy_idle_res%0d", i), 32'(res[3]), 32'd0);
        end

        // Node still works normally after the abort.
        do_op(3, {16'h0000, 16'hC0DE, 16'h0000}, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
